// File: rtl/mant_mul_seq_if.sv
// Operand/result handshake bundle between the mantissa operand driver and mant_mul_seq.
// Latency: none (wires only).
// Backpressure: in_valid/in_ready gate operand transfer; out_valid/out_ready gate product transfer.
// Signals: in_valid/in_ready/mul_a/mul_b (operand side), out_valid/out_ready/mul_res (result side), busy (status).
interface mant_mul_seq_if #(
  parameter int DWIDTH = 11
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DWIDTH-1:0]     mul_a;
  logic [DWIDTH-1:0]     mul_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*DWIDTH-1:0]   mul_res;
  logic                  busy;

  // Operand driver / product consumer side.
  modport master (
    output in_valid, mul_a, mul_b, out_ready,
    input  in_ready, out_valid, mul_res, busy
  );

  // Multiplier side.
  modport slave (
    input  in_valid, mul_a, mul_b, out_ready,
    output in_ready, out_valid, mul_res, busy
  );
endinterface

// File: rtl/mant_mul_seq.sv
// Sequential unsigned mantissa multiplier, radix-2 shift-add, one multiplier bit per cycle.
// Latency: accept edge k -> out_valid from cycle k+DWIDTH; minimum transaction period DWIDTH+2.
// Backpressure: holds product with out_valid high indefinitely until out_ready; no operand accept until then.
// Ports: clk (rising edge), rst (synchronous, active-high), bus (mant_mul_seq_if.slave:
//   in_valid/in_ready/mul_a/mul_b in, out_valid/out_ready/mul_res out, busy status).
module mant_mul_seq #(
  parameter  int DWIDTH = 11,
  localparam int CWIDTH = $clog2(DWIDTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  mant_mul_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CWIDTH-1:0]     cnt_q, cnt_d;
  logic [DWIDTH-1:0]     a_q, a_d;
  logic [DWIDTH-1:0]     b_q, b_d;
  logic [2*DWIDTH-1:0]   acc_q, acc_d;
  logic [2*DWIDTH-1:0]   res_q, res_d;

  logic [2*DWIDTH-1:0]   a_ext;
  logic [2*DWIDTH-1:0]   pp;
  logic [2*DWIDTH-1:0]   acc_sum;
  logic                  last_iter;

  // Partial product: multiplicand weighted by the current multiplier bit position.
  // Width is 2*DWIDTH so the running sum can never wrap, even for all-ones operands.
  assign a_ext     = {{DWIDTH{1'b0}}, a_q};
  assign pp        = b_q[0] ? (a_ext << cnt_q) : '0;
  assign acc_sum   = acc_q + pp;
  assign last_iter = (cnt_q == CWIDTH'(DWIDTH - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.mul_a;
          b_d     = bus.mul_b;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        acc_d = acc_sum;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + CWIDTH'(1);
        // The final iteration's partial product goes straight into the result
        // register so the product is visible the cycle DONE is entered.
        if (last_iter) begin
          res_d   = acc_sum;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.busy      = (state_q == S_BUSY);
  assign bus.mul_res   = res_q;

  // Protocol properties.
  a_ready_valid_excl : assert property (@(posedge clk) !(bus.in_ready && bus.out_valid));
  a_res_stable       : assert property (@(posedge clk)
                         (bus.out_valid && !bus.out_ready && !rst) |=> $stable(bus.mul_res));
  a_busy_not_ready   : assert property (@(posedge clk) bus.busy |-> !bus.in_ready);

endmodule

// File: tb/tb_mant_mul_seq.sv
module tb_mant_mul_seq;
  localparam int DW = 11;

  typedef struct {
    logic [DW-1:0]   a;
    logic [DW-1:0]   b;
    logic [2*DW-1:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mant_mul_seq_if #(.DWIDTH(DW)) bus ();

  mant_mul_seq #(.DWIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference product: plain integer multiplication.
  function automatic logic [63:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint unsigned x, y;
    x = 64'(a);
    y = 64'(b);
    return x * y;
  endfunction

  // Accept one operand pair and wait (bounded) for out_valid.
  task automatic run_op(input logic [DW-1:0] a, input logic [DW-1:0] b,
                        output logic [2*DW-1:0] res, output int lat);
    check("ready_before_op", 64'(bus.in_ready), 64'd1);
    bus.mul_a    = a;
    bus.mul_b    = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("busy_after_accept", 64'(bus.busy), 64'd1);
    check("not_ready_in_busy", 64'(bus.in_ready), 64'd0);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      tick();
      lat++;
    end
    res = bus.mul_res;
  endtask

  vec_t            vecs[6];
  logic [2*DW-1:0] res;
  int              lat;
  logic [63:0]     q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{a: 11'h003, b: 11'h005, exp: 22'h00000F};
    vecs[1] = '{a: 11'h7FF, b: 11'h7FF, exp: 22'h3FF001};
    vecs[2] = '{a: 11'h000, b: 11'h7FF, exp: 22'h000000};
    vecs[3] = '{a: 11'h400, b: 11'h400, exp: 22'h100000};
    vecs[4] = '{a: 11'h123, b: 11'h456, exp: 22'h04EDC2};
    vecs[5] = '{a: 11'h7FF, b: 11'h000, exp: 22'h000000};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.mul_a    = '0;
    bus.mul_b    = '0;
    tick();
    tick();
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_mul_res", 64'(bus.mul_res), 64'd0);
    rst = 1'b0;
    tick();

    // Table-driven vectors with immediate consumption.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, res, lat);
      check("vec_latency", 64'(lat), 64'(DW));
      check("vec_res", 64'(res), 64'(vecs[i].exp));
      tick();
      check("vec_valid_one_cycle", 64'(bus.out_valid), 64'd0);
      check("vec_ready_after", 64'(bus.in_ready), 64'd1);
      check("vec_res_retained", 64'(bus.mul_res), 64'(vecs[i].exp));
    end

    // Backpressure: operand/in_valid noise while BUSY and DONE must be ignored.
    bus.out_ready = 1'b0;
    bus.mul_a     = 11'h123;
    bus.mul_b     = 11'h456;
    bus.in_valid  = 1'b1;
    tick();
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      bus.in_valid = 1'($urandom);
      bus.mul_a    = DW'($urandom);
      bus.mul_b    = DW'($urandom);
      tick();
      lat++;
    end
    check("bp_latency", 64'(lat), 64'(DW));
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.mul_a    = DW'($urandom);
      bus.mul_b    = DW'($urandom);
      tick();
      check("bp_out_valid", 64'(bus.out_valid), 64'd1);
      check("bp_res_stable", 64'(bus.mul_res), 64'h04EDC2);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("bp_release_valid", 64'(bus.out_valid), 64'd0);
    check("bp_release_ready", 64'(bus.in_ready), 64'd1);

    // Continuous traffic with random operands, scoreboarded against the model.
    begin
      int popped   = 0;
      int cyc      = 0;
      int last_acc = -1;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      while (popped < 100 && cyc < 3000) begin
        bus.mul_a = DW'($urandom);
        bus.mul_b = DW'($urandom);
        if (bus.in_ready) begin
          q.push_back(ref_mul(bus.mul_a, bus.mul_b));
          if (last_acc >= 0) check("rand_accept_spacing", 64'(cyc - last_acc), 64'(DW + 2));
          last_acc = cyc;
        end
        if (bus.out_valid) begin
          if (q.size() == 0) check("rand_unexpected_out", 64'd1, 64'd0);
          else check("rand_res", 64'(bus.mul_res), q.pop_front());
          popped++;
        end
        tick();
        cyc++;
      end
      check("rand_count", 64'(popped), 64'd100);
      bus.in_valid = 1'b0;
      tick();
      tick();
      q.delete();
    end

    // Reset in the fifth BUSY cycle of an all-ones multiply.
    bus.mul_a    = 11'h7FF;
    bus.mul_b    = 11'h7FF;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    tick();
    check("rst_busy_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy_mul_res", 64'(bus.mul_res), 64'd0);
    check("rst_busy_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_busy_busy", 64'(bus.busy), 64'd0);
    rst = 1'b0;
    run_op(11'h002, 11'h003, res, lat);
    check("post_rst_latency", 64'(lat), 64'(DW));
    check("post_rst_res", 64'(res), 64'h000006);
    tick();

    // Reset while holding a product in DONE.
    bus.out_ready = 1'b0;
    run_op(11'h005, 11'h005, res, lat);
    check("done_res", 64'(res), 64'd25);
    rst = 1'b1;
    tick();
    check("rst_done_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_done_mul_res", 64'(bus.mul_res), 64'd0);
    check("rst_done_in_ready", 64'(bus.in_ready), 64'd1);

    // Reset wins over a same-cycle operand handshake.
    bus.in_valid = 1'b1;
    bus.mul_a    = 11'h00F;
    bus.mul_b    = 11'h00F;
    tick();
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    check("rst_vs_accept_busy", 64'(bus.busy), 64'd0);
    tick();
    check("rst_vs_accept_idle", 64'(bus.in_ready), 64'd1);
    check("rst_vs_accept_res", 64'(bus.mul_res), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
